// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: FSM states and the ALU opcode encoding.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [2:0] alu_op_t;

  // Opcode encoding understood by method_ALU
  localparam alu_op_t OP_ADD   = 3'd0;  // {cout,Q} = A + B + cin
  localparam alu_op_t OP_SUB   = 3'd1;  // {cout,Q} = A - B - cin, cout = borrow
  localparam alu_op_t OP_AND   = 3'd2;
  localparam alu_op_t OP_OR    = 3'd3;
  localparam alu_op_t OP_XOR   = 3'd4;
  localparam alu_op_t OP_NOT   = 3'd5;  // Q = ~A
  localparam alu_op_t OP_SHL   = 3'd6;  // {cout,Q} = {A,cin}
  localparam alu_op_t OP_PASSB = 3'd7;  // Q = B

  localparam int unsigned N_DEF     = 128;
  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between two requesters and the shared ALU arbiter.
//  slave  : arbiter side (takes requests, drives results/status)
//  master : requester/environment side
interface alu_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [N-1:0]     req0_A;
  logic [N-1:0]     req0_B;
  alu_op_t          req0_select;
  logic             req0_cin;
  logic [N-1:0]     req1_A;
  logic [N-1:0]     req1_B;
  alu_op_t          req1_select;
  logic             req1_cin;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [N-1:0]     resp_Q;
  logic             resp_cout;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  req_valid, req0_A, req0_B, req0_select, req0_cin,
           req1_A, req1_B, req1_select, req1_cin, resp_ready,
    output req_ready, resp_valid, resp_Q, resp_cout, busy, op_count
  );

  modport master (
    output req_valid, req0_A, req0_B, req0_select, req0_cin,
           req1_A, req1_B, req1_select, req1_cin, resp_ready,
    input  req_ready, resp_valid, resp_Q, resp_cout, busy, op_count
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// method_ALU: combinational N-bit ALU with carry/borrow out.
//  A, B : operands        select : opcode (alu_op_t)     cin : carry/borrow in
//  Q    : N-bit result    cout   : carry out (borrow for SUB, shifted-out MSB for SHL)
module method_ALU
  import alu_arb_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  alu_op_t      select,
  input  logic         cin,
  output logic [N-1:0] Q,
  output logic         cout
);
  localparam int unsigned W = N + 1;

  logic [N:0] wide;

  // One extra bit carries cout for the arithmetic/shift ops
  always_comb begin
    wide = '0;
    case (select)
      OP_ADD:   wide = W'(A) + W'(B) + W'(cin);
      OP_SUB:   wide = W'(A) - W'(B) - W'(cin);
      OP_AND:   wide = {1'b0, A & B};
      OP_OR:    wide = {1'b0, A | B};
      OP_XOR:   wide = {1'b0, A ^ B};
      OP_NOT:   wide = {1'b0, ~A};
      OP_SHL:   wide = {A, cin};
      OP_PASSB: wide = {1'b0, B};
      default:  wide = '0;
    endcase
  end

  assign Q    = wide[N-1:0];
  assign cout = wide[N];
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one method_ALU between two requesters.
//  CLK, RST_N : clock (posedge) and async active-low reset
//  bus        : alu_arbiter_if.slave -- requests in, one-hot req_ready accept,
//               one-hot resp_valid with resp_Q/resp_cout held until the owner
//               raises its resp_ready, busy, completed-op counter op_count.
// Sequence per op: IDLE (accept) -> EXEC (ALU on latched operands) -> RESP.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic         CLK,
  input  logic         RST_N,
  alu_arbiter_if.slave bus
);
  state_t           state_q, state_d;
  logic             rr_ptr_q;
  logic             owner_q;
  logic [N-1:0]     a_q, b_q;
  alu_op_t          sel_q;
  logic             cin_q;
  logic [N-1:0]     q_q;
  logic             cout_q;
  logic [CNT_W-1:0] op_count_q;

  logic             grant;
  logic             accept;
  logic             done;
  logic [1:0]       req_ready_c;
  logic [1:0]       resp_valid_c;
  logic [N-1:0]     alu_q;
  logic             alu_cout;

  // ALU only ever sees the latched copy, so requesters may change operands after accept
  method_ALU #(.N(N)) u_alu (
    .A      (a_q),
    .B      (b_q),
    .select (sel_q),
    .cin    (cin_q),
    .Q      (alu_q),
    .cout   (alu_cout)
  );

  // Next-state, grant and handshake decode
  always_comb begin
    state_d      = state_q;
    grant        = rr_ptr_q;
    accept       = 1'b0;
    done         = 1'b0;
    req_ready_c  = 2'b00;
    resp_valid_c = 2'b00;
    case (state_q)
      IDLE: begin
        // Ready is masked while reset is held so no accept is advertised then
        if (RST_N && (bus.req_valid != 2'b00)) begin
          grant              = bus.req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
          req_ready_c[grant] = 1'b1;
          accept             = 1'b1;
          state_d            = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        resp_valid_c[owner_q] = 1'b1;
        // Only the owner's ready can complete the op
        if (bus.resp_ready[owner_q]) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All architectural state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 1'b0;
      owner_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      cin_q      <= 1'b0;
      q_q        <= '0;
      cout_q     <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q  <= grant;
        rr_ptr_q <= ~grant;
        a_q      <= grant ? bus.req1_A      : bus.req0_A;
        b_q      <= grant ? bus.req1_B      : bus.req0_B;
        sel_q    <= grant ? bus.req1_select : bus.req0_select;
        cin_q    <= grant ? bus.req1_cin    : bus.req0_cin;
      end
      if (state_q == EXEC) begin
        q_q    <= alu_q;
        cout_q <= alu_cout;
      end
      // Counter wraps naturally
      if (done) op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_Q     = q_q;
  assign bus.resp_cout  = cout_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.op_count   = op_count_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int unsigned N     = 128;
  localparam int unsigned CNT_W = 16;

  logic CLK;
  logic RST_N;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_arbiter_if #(.N(N), .CNT_W(CNT_W)) bus ();

  alu_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [N-1:0] all_ones;
  logic [N-1:0] exp_q;
  logic         exp_c;
  logic [1:0]   exp_oh;

  initial begin
    all_ones = '1;

    RST_N           = 1'b0;
    bus.req_valid   = 2'b11;
    bus.req0_A      = '0;
    bus.req0_B      = '0;
    bus.req0_select = OP_ADD;
    bus.req0_cin    = 1'b0;
    bus.req1_A      = '0;
    bus.req1_B      = '0;
    bus.req1_select = OP_ADD;
    bus.req1_cin    = 1'b0;
    bus.resp_ready  = 2'b00;

    // 1: reset held with both requests valid
    repeat (3) tick();
    chk("rst_req_ready",  N'(bus.req_ready),  '0);
    chk("rst_resp_valid", N'(bus.resp_valid), '0);
    chk("rst_resp_Q",     bus.resp_Q,         '0);
    chk("rst_cout",       N'(bus.resp_cout),  '0);
    chk("rst_busy",       N'(bus.busy),       '0);
    chk("rst_op_count",   N'(bus.op_count),   '0);
    bus.req_valid = 2'b00;
    RST_N         = 1'b1;
    tick();

    // 2: single op 5+3 on requester 0
    bus.req0_A = N'(5); bus.req0_B = N'(3); bus.req0_select = OP_ADD; bus.req0_cin = 1'b0;
    bus.req_valid = 2'b01;
    #1;
    chk("t2_req_ready", N'(bus.req_ready), N'(2'b01));
    tick();
    bus.req_valid = 2'b00;
    chk("t2_busy_exec",  N'(bus.busy),       N'(1));
    chk("t2_no_resp_ex", N'(bus.resp_valid), '0);
    tick();
    chk("t2_resp_valid", N'(bus.resp_valid), N'(2'b01));
    chk("t2_resp_Q",     bus.resp_Q,         N'(8));
    chk("t2_cout",       N'(bus.resp_cout),  '0);
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = 2'b00;
    chk("t2_op_count", N'(bus.op_count),   N'(1));
    chk("t2_busy",     N'(bus.busy),       '0);
    chk("t2_resp_clr", N'(bus.resp_valid), '0);

    // 3: carry out of the full width on requester 1 (rr_ptr now points at 1)
    bus.req1_A = all_ones; bus.req1_B = N'(1); bus.req1_select = OP_ADD; bus.req1_cin = 1'b0;
    bus.req_valid = 2'b10;
    #1;
    chk("t3_req_ready", N'(bus.req_ready), N'(2'b10));
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("t3_resp_valid", N'(bus.resp_valid), N'(2'b10));
    chk("t3_resp_Q",     bus.resp_Q,         '0);
    chk("t3_cout",       N'(bus.resp_cout),  N'(1));
    bus.resp_ready = 2'b10;
    tick();
    bus.resp_ready = 2'b00;
    chk("t3_op_count", N'(bus.op_count), N'(2));

    // 4: both valid continuously -> grants alternate 0,1,0,1
    // req0: 10+20 = 30; req1: 7-100 = -93 with borrow
    bus.req0_A = N'(10);  bus.req0_B = N'(20);  bus.req0_select = OP_ADD; bus.req0_cin = 1'b0;
    bus.req1_A = N'(7);   bus.req1_B = N'(100); bus.req1_select = OP_SUB; bus.req1_cin = 1'b0;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_q  = (i % 2 == 0) ? N'(30) : (all_ones - N'(92));
      exp_c  = (i % 2 == 0) ? 1'b0 : 1'b1;
      #1;
      chk($sformatf("t4_grant%0d", i), N'(bus.req_ready), N'(exp_oh));
      tick();
      chk($sformatf("t4_ready_exec%0d", i), N'(bus.req_ready), '0);
      tick();
      chk($sformatf("t4_owner%0d", i), N'(bus.resp_valid), N'(exp_oh));
      chk($sformatf("t4_Q%0d", i),     bus.resp_Q,         exp_q);
      chk($sformatf("t4_cout%0d", i),  N'(bus.resp_cout),  N'(exp_c));
      bus.resp_ready = 2'b11;
      tick();
      bus.resp_ready = 2'b00;
    end
    bus.req_valid = 2'b00;
    chk("t4_op_count", N'(bus.op_count), N'(6));

    // 5: backpressure; operands change after accept, latched copy must be used
    bus.req0_A = N'(32'hF0); bus.req0_B = N'(32'h0F); bus.req0_select = OP_OR;
    bus.req_valid = 2'b11;
    #1;
    chk("t5_grant", N'(bus.req_ready), N'(2'b01));
    tick();
    bus.req0_A = N'(32'h1234); bus.req0_select = OP_XOR;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t5_hold_valid%0d", i), N'(bus.resp_valid), N'(2'b01));
      chk($sformatf("t5_hold_Q%0d", i),     bus.resp_Q,         N'(32'hFF));
      chk($sformatf("t5_hold_ready%0d", i), N'(bus.req_ready),  '0);
      tick();
    end
    bus.resp_ready = 2'b10;
    tick();
    chk("t5_nonowner_valid", N'(bus.resp_valid), N'(2'b01));
    chk("t5_nonowner_cnt",   N'(bus.op_count),   N'(6));
    bus.req_valid  = 2'b00;
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = 2'b00;
    chk("t5_op_count", N'(bus.op_count), N'(7));
    chk("t5_busy",     N'(bus.busy),     '0);

    // 6: reset during EXEC discards the op
    bus.req0_A = N'(1); bus.req0_B = N'(1); bus.req0_select = OP_ADD;
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    chk("t6_in_exec", N'(bus.busy), N'(1));
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    repeat (3) tick();
    chk("t6_no_resp",  N'(bus.resp_valid), '0);
    chk("t6_op_count", N'(bus.op_count),   '0);
    chk("t6_busy",     N'(bus.busy),       '0);
    bus.req0_A = N'(6); bus.req0_B = N'(3); bus.req0_select = OP_XOR;
    bus.req_valid = 2'b01;
    #1;
    chk("t6_grant", N'(bus.req_ready), N'(2'b01));
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("t6_resp_valid", N'(bus.resp_valid), N'(2'b01));
    chk("t6_resp_Q",     bus.resp_Q,         N'(5));
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = 2'b00;
    chk("t6_op_count_after", N'(bus.op_count), N'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
